// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: per-frame sprite position sweep, one sprite per cycle, with edge bounce.
// Define SPRITE_VERT_MOTION_EN to also bounce sprites vertically; otherwise y is fixed.
module sprite_motion_sched #(
  parameter int CORDW     = 16,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_CNT   = 4,
  parameter int SPR_DRAWW = 64,
  parameter int SPR_DRAWH = 64,
  parameter int SPR_SPX   = 4,
  parameter int SPR_SPY   = 2
) (
  input  logic                     clk_pix,
  input  logic                     rst_pix,
  input  logic                     frame,
  input  logic                     pause,
  output logic [SPR_CNT*CORDW-1:0] sprx_all,
  output logic [SPR_CNT*CORDW-1:0] spry_all,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam int IW = $clog2(SPR_CNT);
  localparam int W = CORDW + 1;
  localparam logic [CORDW-1:0] Y0 = CORDW'(V_RES / 2 - SPR_DRAWH / 2);
  typedef logic signed [W-1:0] ext_t;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic ovr_q, ovr_d;
  logic [CORDW-1:0] x_q [SPR_CNT];
  logic [CORDW-1:0] x_d [SPR_CNT];
  logic [SPR_CNT-1:0] dx_q, dx_d;
  logic [CORDW:0] mx;
  // Returns {new direction, new position}; arithmetic at CORDW+1 bits so bounds never wrap.
  function automatic logic [CORDW:0] move(ext_t p, logic d, ext_t sp, ext_t lim);
    ext_t up, dn;
    up = p + sp;
    dn = p - sp;
    if (!d) return (up >= lim) ? {1'b1, lim[CORDW-1:0]} : {1'b0, up[CORDW-1:0]};
    return (p <= sp) ? {1'b0, {CORDW{1'b0}}} : {1'b1, dn[CORDW-1:0]};
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ovr_d = ovr_q | (frame && state_q != IDLE);
    if (state_q == IDLE && frame && !pause) begin
      state_d = UPDATE;
      idx_d = '0;
    end
    if (state_q == UPDATE) begin
      idx_d = idx_q + IW'(1);
      state_d = (idx_q == IW'(SPR_CNT - 1)) ? DONE : UPDATE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    mx = move(ext_t'(signed'(x_q[idx_q])), dx_q[idx_q], ext_t'(SPR_SPX), ext_t'(H_RES - SPR_DRAWW));
    x_d = x_q;
    dx_d = dx_q;
    if (state_q == UPDATE) begin
      x_d[idx_q] = mx[CORDW-1:0];
      dx_d[idx_q] = mx[CORDW];
    end
  end
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      idx_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < SPR_CNT; i++) begin
        x_q[i] <= CORDW'(i * (H_RES / SPR_CNT));
        dx_q[i] <= i[0];
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ovr_q <= ovr_d;
      x_q <= x_d;
      dx_q <= dx_d;
    end
  end
  assign busy = state_q == UPDATE;
  assign done = state_q == DONE;
  assign overrun = ovr_q;
  for (genvar g = 0; g < SPR_CNT; g++) begin : g_x
    assign sprx_all[g*CORDW +: CORDW] = x_q[g];
  end
`ifdef SPRITE_VERT_MOTION_EN
  logic [CORDW-1:0] y_q [SPR_CNT];
  logic [CORDW-1:0] y_d [SPR_CNT];
  logic [SPR_CNT-1:0] dy_q, dy_d;
  logic [CORDW:0] my;
  always_comb begin
    my = move(ext_t'(signed'(y_q[idx_q])), dy_q[idx_q], ext_t'(SPR_SPY), ext_t'(V_RES - SPR_DRAWH));
    y_d = y_q;
    dy_d = dy_q;
    if (state_q == UPDATE) begin
      y_d[idx_q] = my[CORDW-1:0];
      dy_d[idx_q] = my[CORDW];
    end
  end
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < SPR_CNT; i++) begin
        y_q[i] <= Y0;
        dy_q[i] <= i[0];
      end
    end else begin
      y_q <= y_d;
      dy_q <= dy_d;
    end
  end
  for (genvar g = 0; g < SPR_CNT; g++) begin : g_y
    assign spry_all[g*CORDW +: CORDW] = y_q[g];
  end
`else
  assign spry_all = {SPR_CNT{Y0}};
`endif
endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb_sprite_motion_sched: directed table, bounce sequences and random frames vs. a frame-level model.
module tb_sprite_motion_sched;
  localparam int CW = 16;
  localparam int N = 4;
  logic clk_pix = 1'b0;
  logic rst_pix, frame, pause;
  logic [N*CW-1:0] sprx_all, spry_all;
  logic busy, done, overrun;
  int checks = 0;
  int errors = 0;
  int cur [N];
  int old [N];
  int dir [N];
  int n = 0;
  bit ovr = 1'b0;
  typedef struct {bit r, f, p, b, d, o; int x0, x3;} vec_t;
  vec_t tv [20];

  sprite_motion_sched dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .pause(pause),
    .sprx_all(sprx_all), .spry_all(spry_all), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Whole-frame motion rule for one sprite along x.
  task automatic mv(inout int x, inout int d);
    if (d == 0) begin
      if (x + 4 >= 576) begin x = 576; d = 1; end
      else x = x + 4;
    end else begin
      if (x <= 4) begin x = 0; d = 0; end
      else x = x - 4;
    end
  endtask

  // n counts edges since the accepting edge: busy for n=1..N, done at N+1, idle when 0.
  task automatic model_edge(input bit r, input bit f, input bit p);
    if (r) begin
      for (int i = 0; i < N; i++) begin
        cur[i] = i * 160;
        old[i] = i * 160;
        dir[i] = i % 2;
      end
      n = 0;
      ovr = 1'b0;
    end else if (n > 0) begin
      if (f) ovr = 1'b1;
      n = (n == N + 1) ? 0 : n + 1;
    end else if (f && !p) begin
      old = cur;
      for (int i = 0; i < N; i++) mv(cur[i], dir[i]);
      n = 1;
    end
  endtask

  function automatic logic [N*CW-1:0] expx();
    logic [N*CW-1:0] v;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'((n == 0 || n >= 2 + k) ? cur[k] : old[k]);
    return v;
  endfunction

  task automatic cyc(input bit r, input bit f, input bit p);
    rst_pix = r;
    frame = f;
    pause = p;
    @(posedge clk_pix);
    model_edge(r, f, p);
    @(negedge clk_pix);
    chk("sprx", sprx_all, expx());
    chk("spry", spry_all, {N{16'd208}});
    chk("busy", busy, (n >= 1 && n <= N));
    chk("done", done, (n == N + 1));
    chk("overrun", overrun, ovr);
  endtask

  initial begin
    tv[0]  = '{1,0,0, 0,0,0, 0,480};
    tv[1]  = '{0,1,0, 1,0,0, 0,480};
    tv[2]  = '{0,0,0, 1,0,0, 4,480};
    tv[3]  = '{0,0,0, 1,0,0, 4,480};
    tv[4]  = '{0,0,0, 1,0,0, 4,480};
    tv[5]  = '{0,0,0, 0,1,0, 4,476};
    tv[6]  = '{0,0,0, 0,0,0, 4,476};
    tv[7]  = '{0,1,1, 0,0,0, 4,476};
    tv[8]  = '{0,0,0, 0,0,0, 4,476};
    tv[9]  = '{0,1,0, 1,0,0, 4,476};
    tv[10] = '{0,1,0, 1,0,1, 8,476};
    tv[11] = '{0,0,0, 1,0,1, 8,476};
    tv[12] = '{0,0,0, 1,0,1, 8,476};
    tv[13] = '{0,0,0, 0,1,1, 8,472};
    tv[14] = '{0,0,0, 0,0,1, 8,472};
    tv[15] = '{1,0,0, 0,0,0, 0,480};
    tv[16] = '{0,1,0, 1,0,0, 0,480};
    tv[17] = '{0,0,0, 1,0,0, 4,480};
    tv[18] = '{1,0,0, 0,0,0, 0,480};
    tv[19] = '{0,0,0, 0,0,0, 0,480};
    rst_pix = 1'b1;
    frame = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(tv[i].r, tv[i].f, tv[i].p);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].b);
      chk($sformatf("tv%0d_done", i), done, tv[i].d);
      chk($sformatf("tv%0d_ovr", i), overrun, tv[i].o);
      chk($sformatf("tv%0d_x0", i), sprx_all[CW-1:0], CW'(tv[i].x0));
      chk($sformatf("tv%0d_x3", i), sprx_all[3*CW +: CW], CW'(tv[i].x3));
    end
    cyc(1, 0, 0);
    for (int j = 1; j <= 145; j++) begin
      cyc(0, 1, 0);
      repeat (6) cyc(0, 0, 0);
      if (j == 120) chk("left_bounce_x3", sprx_all[3*CW +: CW], 0);
      if (j == 121) chk("left_after_x3", sprx_all[3*CW +: CW], 4);
      if (j == 144) chk("right_bounce_x0", sprx_all[CW-1:0], 576);
      if (j == 145) chk("right_after_x0", sprx_all[CW-1:0], 572);
    end
    repeat (3000) cyc($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
